// File: rtl/stopwatch_sequencer.sv
// stopwatch_sequencer: key conditioning plus IDLE/RUN/PAUSE/STOP run control for the stopwatch counters.
// Optional LAP_HOLD_EN adds key_lap and the disp_hold display-freeze output.
module stopwatch_sequencer #(
    parameter int DB_CYCLES = 500000,
    parameter int TICK_DIV  = 500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_start,
    input  logic       key_pause,
    input  logic       key_load,
`ifdef LAP_HOLD_EN
    input  logic       key_lap,
    output logic       disp_hold,
`endif
    output logic       cnt_clr,
    output logic       cnt_tick,
    output logic       cnt_load,
    output logic       running,
    output logic [1:0] state
);
    localparam int DW = $clog2(DB_CYCLES);
    localparam int PW = $clog2(TICK_DIV);
`ifdef LAP_HOLD_EN
    localparam int NK = 4;
`else
    localparam int NK = 3;
`endif

    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10, STOP = 2'b11} state_t;

    logic [NK-1:0] raw, s1, s2, ev;
    state_t        cur, nxt;
    logic [PW-1:0] pre;
    logic          ev_start, ev_pause, ev_load, leave_stop;

`ifdef LAP_HOLD_EN
    assign raw = {key_lap, key_load, key_pause, key_start};
`else
    assign raw = {key_load, key_pause, key_start};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // The counter only runs while the synced level differs from the accepted one,
    // so any bounce back to the accepted level restarts the qualification.
    for (genvar g = 0; g < NK; g++) begin : g_key
        logic [DW-1:0] cnt;
        logic          lvl, hit;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt <= '0;
                lvl <= 1'b0;
                hit <= 1'b0;
            end else begin
                hit <= 1'b0;
                if (s2[g] == lvl) begin
                    cnt <= '0;
                end else if (cnt == DW'(DB_CYCLES - 1)) begin
                    cnt <= '0;
                    lvl <= s2[g];
                    hit <= s2[g];
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
        assign ev[g] = hit;
    end

    assign ev_start   = ev[0];
    assign ev_pause   = ev[1];
    assign ev_load    = ev[2];
    assign leave_stop = (cur == STOP) && (nxt == IDLE);

    always_comb begin
        nxt = cur;
        if (ev_start)
            nxt = (cur == IDLE) ? RUN : (cur == STOP) ? IDLE : STOP;
        else if (ev_pause && (cur == RUN || cur == PAUSE))
            nxt = (cur == RUN) ? PAUSE : RUN;
    end

    // A tick is only issued if the watch is still running in the wrap cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur      <= IDLE;
            pre      <= '0;
            cnt_clr  <= 1'b0;
            cnt_tick <= 1'b0;
            cnt_load <= 1'b0;
            running  <= 1'b0;
        end else begin
            cur      <= nxt;
            running  <= (nxt == RUN);
            cnt_clr  <= leave_stop;
            cnt_tick <= (cur == RUN) && (nxt == RUN) && (pre == PW'(TICK_DIV - 1));
            cnt_load <= (cur == IDLE) && ev_load && !ev_start;
            pre      <= leave_stop ? '0 :
                        (cur != RUN) ? pre :
                        (pre == PW'(TICK_DIV - 1)) ? '0 : pre + 1'b1;
        end
    end

`ifdef LAP_HOLD_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            disp_hold <= 1'b0;
        else if (nxt == IDLE && cur != IDLE)
            disp_hold <= 1'b0;
        else if ((cur == RUN || cur == PAUSE) && ev[3] && !ev_start && !ev_pause)
            disp_hold <= ~disp_hold;
    end
`endif

    assign state = cur;
endmodule
